mmio_memory: RTL and testbench
==============================

Name: mmio_memory

Overview:
- Unified memory system of the pipelined CPU: dual-read/single-write word RAM, a VGA frame buffer, and memory-mapped PS/2, UART and timer registers.
- Port 0 serves instruction fetch and port 1 serves data.
- Sits between the CPU and the ps2/vga/uart blocks in the top level.
- Also produces the memory-sourced interrupt vector.

Parameters:
- RAM_WORDS, 16384, number of 32-bit RAM words, mapped at word address 0.
- FB_W, 80, frame-buffer width in cells; each cell is 8x8 screen pixels.
- FB_H, 60, frame-buffer height in cells.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- clk_en  input  1  CPU advance enable; when low, all CPU-side reads and writes are frozen.
- raddr0  input  18  port-0 word address (fetch).
- rdata0  output  32  port-0 read data.
- raddr1  input  18  port-1 word address (data).
- rdata1  output  32  port-1 read data.
- wen  input  4  byte write enables; bit3 covers data[31:24] and bit0 covers data[7:0].
- waddr  input  18  write word address.
- wdata  input  32  write data.
- ps2_ren  output  1  one-cycle pop pulse to the PS/2 block.
- ps2_data_in  input  16  PS/2 keycode word.
- pixel_x_in  input  10  VGA x, 0..639.
- pixel_y_in  input  10  VGA y, 0..479.
- pixel  output  12  {B,G,R} 4 bits each.
- uart_tx_data  output  8  byte to transmit.
- uart_tx_wen  output  1  one-cycle transmit strobe.
- uart_rx_data  input  8  received byte.
- uart_rx_ren  output  1  one-cycle receive-pop strobe.
- interrupts  output  16  memory-sourced interrupt lines.

Behaviour:
Address map (18-bit word addresses):
- RAM: 0x00000 .. RAM_WORDS-1.
- Frame buffer: 0x20000 + y*FB_W + x.
- 0x3FF00: PS2_DATA, read only.
- 0x3FF01: UART_TX, write only.
- 0x3FF02: UART_RX, read only.
- 0x3FF04: TIMER_RELOAD, read/write.
- 0x3FF05: TIMER_COUNT, read only.

Reads:
- Synchronous, one-cycle latency: the address sampled at a clk edge with clk_en=1 appears on rdata the following cycle.
- With clk_en=0, rdata holds its value.
- Unmapped or write-only addresses read 0.
- Frame buffer reads return {20'b0, cell}.
- PS2_DATA reads return {16'b0, ps2_data_in}.
- UART_RX reads return {24'b0, uart_rx_data}.

Read side effects (port 1 only):
- A port-1 read of PS2_DATA with clk_en=1 asserts ps2_ren for exactly one cycle, registered and coincident with the data.
- A port-1 read of UART_RX with clk_en=1 asserts uart_rx_ren likewise.
- Port-0 reads of I/O addresses return the same values but never cause side effects.

Writes:
- Occur at the clk edge only when clk_en=1; each byte is gated by its wen bit.
- Frame buffer stores wdata[11:0]; it is written when wen[0] or wen[1] is set, with byte lanes applied to bits [7:0] and [11:8].
- A write to UART_TX with wen[0]=1 registers uart_tx_data=wdata[7:0] and pulses uart_tx_wen for one cycle.
- Writes to read-only or unmapped addresses are ignored.

Collisions:
- Read and write to the same address in the same cycle: the read returns the old data (read-first).
- Both read ports may address the same word in the same cycle.

Timer:
- Counter decrements on each clk_en=1 cycle while TIMER_RELOAD is nonzero.
- When the counter is 0 or 1 it reloads from TIMER_RELOAD, and interrupts[0] pulses high for one cycle.
- Writing TIMER_RELOAD also loads the counter.
- TIMER_RELOAD=0 stops the timer, with no interrupt.
- interrupts[15:1] are always 0.

Display:
- cell = fb[(pixel_y_in>>3)*FB_W + (pixel_x_in>>3)].
- pixel is registered with one-cycle latency and is independent of clk_en.
- Output is 0 when x>=640 or y>=480.

Reset:
- Clears rdata0, rdata1, pixel, all strobes, uart_tx_data, interrupts, TIMER_RELOAD and the counter.
- RAM and frame-buffer contents are not reset.
- A reset asserted mid-operation suppresses any pending strobe.

Decomposition:
- A shared package holds the address-map constants (RAM_BASE, FB_BASE, PS2_DATA_ADDR, UART_TX_ADDR, UART_RX_ADDR, TIMER_RELOAD_ADDR, TIMER_COUNT_ADDR) and the pixel-scale shift.
- One natural sub-module, mmio_ram_bank: a byte-enabled 2-read/1-write synchronous RAM, reused for both main RAM and the frame buffer.

Test Plan:
- Byte-enable write and readback: write 0xDEADBEEF to 0x00010 with wen=1111, then with wen=0010 write 0x00001100 → rdata1=0xDEAD11EF one cycle after the read, and rdata0 shows the same value on port 0.
- clk_en gating: with clk_en=0, write 0x12345678 to 0x00020 → later read returns the prior value, and rdata stays frozen during the stall.
- PS/2 pop, port dependence: with ps2_data_in=0x001C, a port-1 read of 0x3FF00 → rdata1=0x0000001C and ps2_ren high for exactly 1 cycle; a port-0 read of the same address → no ps2_ren.
- UART transmit: write 0x41 to 0x3FF01 → uart_tx_data=0x41 and uart_tx_wen pulses for 1 cycle; a port-1 read of 0x3FF02 with uart_rx_data=0x5A → rdata1=0x5A and uart_rx_ren pulses for 1 cycle.
- Frame buffer display: write 0xF0A to 0x20000+1*80+2 → with pixel_x_in=20 and pixel_y_in=9, pixel=0xF0A the next cycle; with x=700, pixel=0.
- Timer: write TIMER_RELOAD=5 → interrupts[0] pulses every 5 clk_en cycles; writing 0 stops the pulses; asserting rst mid-count clears everything.

Source files
------------

// File: rtl/mmio_memory_pkg.sv
// ============================================================================
// Module : mmio_memory_pkg
// Brief  : Address map, display constants and helpers shared by the mmio_memory block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_memory_pkg;

    localparam int ADDR_W = 18;

    localparam logic [ADDR_W-1:0] RAM_BASE          = 18'h00000;
    localparam logic [ADDR_W-1:0] FB_BASE           = 18'h20000;
    localparam logic [ADDR_W-1:0] PS2_DATA_ADDR     = 18'h3FF00;
    localparam logic [ADDR_W-1:0] UART_TX_ADDR      = 18'h3FF01;
    localparam logic [ADDR_W-1:0] UART_RX_ADDR      = 18'h3FF02;
    localparam logic [ADDR_W-1:0] TIMER_RELOAD_ADDR = 18'h3FF04;
    localparam logic [ADDR_W-1:0] TIMER_COUNT_ADDR  = 18'h3FF05;

    localparam int         PIX_SHIFT = 3;
    localparam logic [9:0] SCREEN_W  = 10'd640;
    localparam logic [9:0] SCREEN_H  = 10'd480;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_FB   = 2'd2,
        SRC_IO   = 2'd3
    } rd_src_e;

    function automatic logic [31:0] apply_wen(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_ram_bank.sv
// ============================================================================
// Module : mmio_ram_bank
// Brief  : Byte-enabled synchronous RAM, NR registered read ports, one write port (read-first).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_ram_bank #(
    parameter  int DEPTH = 16384,
    parameter  int DW    = 32,
    parameter  int NR    = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = (DW + 7) / 8
) (
    input  logic                   clk,
    input  logic [NR-1:0]          ren,
    input  logic [NR-1:0][AW-1:0]  raddr,
    output logic [NR-1:0][DW-1:0]  rdata,
    input  logic [NB-1:0]          we,
    input  logic [AW-1:0]          waddr,
    input  logic [DW-1:0]          wdata
);

    logic [DW-1:0]         mem [DEPTH];
    logic [NR-1:0][DW-1:0] rdata_q;
    logic [DW-1:0]         bit_mask;

    // The top lane may be narrower than 8 bits (e.g. 12-bit frame-buffer cells).
    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < DW; k++) bit_mask[k] = we[k/8];
    end

    always_ff @(posedge clk) begin
        if (|we) mem[waddr] <= (mem[waddr] & ~bit_mask) | (wdata & bit_mask);
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (ren[r]) rdata_q[r] <= mem[raddr[r]];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mmio_memory.sv
// ============================================================================
// Module : mmio_memory
// Brief  : CPU memory system: 2R/1W RAM, VGA frame buffer, PS/2, UART and timer registers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_memory
    import mmio_memory_pkg::*;
#(
    parameter int RAM_WORDS = 16384,
    parameter int FB_W      = 80,
    parameter int FB_H      = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [17:0] raddr0,
    output logic [31:0] rdata0,
    input  logic [17:0] raddr1,
    output logic [31:0] rdata1,
    input  logic [3:0]  wen,
    input  logic [17:0] waddr,
    input  logic [31:0] wdata,
    output logic        ps2_ren,
    input  logic [15:0] ps2_data_in,
    input  logic [9:0]  pixel_x_in,
    input  logic [9:0]  pixel_y_in,
    output logic [11:0] pixel,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_wen,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_ren,
    output logic [15:0] interrupts
);

    localparam int FB_CELLS = FB_W * FB_H;
    localparam int RAM_AW   = $clog2(RAM_WORDS);
    localparam int FB_AW    = $clog2(FB_CELLS);

    function automatic logic ram_hit(input logic [ADDR_W-1:0] a);
        return (a - RAM_BASE) < ADDR_W'(RAM_WORDS);
    endfunction

    function automatic logic fb_hit(input logic [ADDR_W-1:0] a);
        return (a - FB_BASE) < ADDR_W'(FB_CELLS);
    endfunction

    logic [1:0][ADDR_W-1:0] ra;
    assign ra = {raddr1, raddr0};

    rd_src_e     src_q [2], src_d [2];
    logic [31:0] io_q  [2], io_d  [2];
    logic        ps2_ren_q, ps2_ren_d, rx_ren_q, rx_ren_d, tx_wen_q, tx_wen_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] reload_q, reload_d, count_q, count_d, reload_new;
    logic        irq_q, irq_d, pix_valid_q, pix_valid_d;
    logic        on_screen;

    logic [1:0]             ram_ren;
    logic [1:0][RAM_AW-1:0] ram_raddr;
    logic [1:0][31:0]       ram_rdata;
    logic [3:0]             ram_we;
    logic [2:0]             fb_ren;
    logic [2:0][FB_AW-1:0]  fb_raddr;
    logic [2:0][11:0]       fb_rdata;
    logic [1:0]             fb_we;

    assign on_screen  = (pixel_x_in < SCREEN_W) && (pixel_y_in < SCREEN_H);
    assign reload_new = apply_wen(reload_q, wdata, wen);

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ram_ren[p]   = clk_en && ram_hit(ra[p]);
            ram_raddr[p] = RAM_AW'(ra[p] - RAM_BASE);
            fb_ren[p]    = clk_en && fb_hit(ra[p]);
            fb_raddr[p]  = FB_AW'(ra[p] - FB_BASE);
        end
        // Display port runs every cycle, independent of the CPU stall.
        fb_ren[2]   = on_screen;
        fb_raddr[2] = FB_AW'(32'(pixel_y_in >> PIX_SHIFT) * FB_W + 32'(pixel_x_in >> PIX_SHIFT));
        ram_we      = (clk_en && ram_hit(waddr)) ? wen : 4'b0;
        fb_we       = (clk_en && fb_hit(waddr)) ? wen[1:0] : 2'b0;
    end

    mmio_ram_bank #(.DEPTH(RAM_WORDS), .DW(32), .NR(2)) u_ram (
        .clk   (clk),
        .ren   (ram_ren),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (RAM_AW'(waddr - RAM_BASE)),
        .wdata (wdata)
    );

    mmio_ram_bank #(.DEPTH(FB_CELLS), .DW(12), .NR(3)) u_fb (
        .clk   (clk),
        .ren   (fb_ren),
        .raddr (fb_raddr),
        .rdata (fb_rdata),
        .we    (fb_we),
        .waddr (FB_AW'(waddr - FB_BASE)),
        .wdata (wdata[11:0])
    );

    always_comb begin
        src_d       = src_q;
        io_d        = io_q;
        ps2_ren_d   = clk_en && (raddr1 == PS2_DATA_ADDR);
        rx_ren_d    = clk_en && (raddr1 == UART_RX_ADDR);
        tx_data_d   = tx_data_q;
        tx_wen_d    = 1'b0;
        reload_d    = reload_q;
        count_d     = count_q;
        irq_d       = 1'b0;
        pix_valid_d = on_screen;
        if (clk_en) begin
            for (int p = 0; p < 2; p++) begin
                io_d[p]  = '0;
                src_d[p] = SRC_NONE;
                if (ram_hit(ra[p]))     src_d[p] = SRC_RAM;
                else if (fb_hit(ra[p])) src_d[p] = SRC_FB;
                else begin
                    src_d[p] = SRC_IO;
                    case (ra[p])
                        PS2_DATA_ADDR:     io_d[p] = {16'b0, ps2_data_in};
                        UART_RX_ADDR:      io_d[p] = {24'b0, uart_rx_data};
                        TIMER_RELOAD_ADDR: io_d[p] = reload_q;
                        TIMER_COUNT_ADDR:  io_d[p] = count_q;
                        default:           io_d[p] = '0;
                    endcase
                end
            end
            if (waddr == UART_TX_ADDR && wen[0]) begin
                tx_data_d = wdata[7:0];
                tx_wen_d  = 1'b1;
            end
            // A reload write restarts the count and takes priority over expiry.
            if (waddr == TIMER_RELOAD_ADDR && |wen) begin
                reload_d = reload_new;
                count_d  = reload_new;
            end else if (reload_q != '0) begin
                if (count_q <= 32'd1) begin
                    count_d = reload_q;
                    irq_d   = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                src_q[p] <= SRC_NONE;
                io_q[p]  <= '0;
            end
            ps2_ren_q   <= 1'b0;
            rx_ren_q    <= 1'b0;
            tx_wen_q    <= 1'b0;
            tx_data_q   <= '0;
            reload_q    <= '0;
            count_q     <= '0;
            irq_q       <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            src_q       <= src_d;
            io_q        <= io_d;
            ps2_ren_q   <= ps2_ren_d;
            rx_ren_q    <= rx_ren_d;
            tx_wen_q    <= tx_wen_d;
            tx_data_q   <= tx_data_d;
            reload_q    <= reload_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    always_comb begin
        case (src_q[0])
            SRC_RAM: rdata0 = ram_rdata[0];
            SRC_FB:  rdata0 = {20'b0, fb_rdata[0]};
            default: rdata0 = io_q[0];
        endcase
        case (src_q[1])
            SRC_RAM: rdata1 = ram_rdata[1];
            SRC_FB:  rdata1 = {20'b0, fb_rdata[1]};
            default: rdata1 = io_q[1];
        endcase
    end

    assign pixel        = pix_valid_q ? fb_rdata[2] : 12'h000;
    assign ps2_ren      = ps2_ren_q;
    assign uart_rx_ren  = rx_ren_q;
    assign uart_tx_wen  = tx_wen_q;
    assign uart_tx_data = tx_data_q;
    assign interrupts   = {15'b0, irq_q};

endmodule

`default_nettype wire

// File: tb/tb_mmio_memory.sv
// ============================================================================
// Module : tb_mmio_memory
// Brief  : Directed self-checking bench for mmio_memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_memory;

    logic        clk, rst, clk_en;
    logic [17:0] raddr0, raddr1, waddr;
    logic [31:0] rdata0, rdata1, wdata;
    logic [3:0]  wen;
    logic        ps2_ren, uart_tx_wen, uart_rx_ren;
    logic [15:0] ps2_data_in, interrupts;
    logic [9:0]  pixel_x_in, pixel_y_in;
    logic [11:0] pixel;
    logic [7:0]  uart_tx_data, uart_rx_data;

    int errors = 0;
    int checks = 0;
    int hits;

    mmio_memory u_dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .raddr0       (raddr0),
        .rdata0       (rdata0),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .ps2_ren      (ps2_ren),
        .ps2_data_in  (ps2_data_in),
        .pixel_x_in   (pixel_x_in),
        .pixel_y_in   (pixel_y_in),
        .pixel        (pixel),
        .uart_tx_data (uart_tx_data),
        .uart_tx_wen  (uart_tx_wen),
        .uart_rx_data (uart_rx_data),
        .uart_rx_ren  (uart_rx_ren),
        .interrupts   (interrupts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
        waddr = a; wdata = d; wen = be;
        tick();
        wen = 4'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        raddr0 = '0; raddr1 = '0; waddr = '0; wdata = '0; wen = '0;
        ps2_data_in = 16'h001C; uart_rx_data = 8'h5A;
        pixel_x_in = 10'd0; pixel_y_in = 10'd0;
        tick(); tick();
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_pixel", {20'b0, pixel}, 32'h0);
        check("rst_strobes", {29'b0, ps2_ren, uart_tx_wen, uart_rx_ren}, 32'h0);
        check("rst_irq", {16'b0, interrupts}, 32'h0);
        rst = 1'b0;

        // Byte-enable write, dual-port readback, read-first collision
        wr(18'h00010, 32'hDEADBEEF, 4'b1111);
        wr(18'h00010, 32'h00001100, 4'b0010);
        raddr0 = 18'h00010; raddr1 = 18'h00010;
        tick();
        check("be_rd1", rdata1, 32'hDEAD11EF);
        check("be_rd0", rdata0, 32'hDEAD11EF);
        wr(18'h00010, 32'h00000011, 4'b0001);
        check("read_first", rdata1, 32'hDEAD11EF);
        tick();
        check("after_wr", rdata1, 32'hDEAD1111);

        // clk_en gating
        wr(18'h00020, 32'hAAAA5555, 4'b1111);
        raddr1 = 18'h00020;
        tick();
        check("pre_stall", rdata1, 32'hAAAA5555);
        clk_en = 1'b0; raddr1 = 18'h00010;
        wr(18'h00020, 32'h12345678, 4'b1111);
        check("stall_hold0", rdata1, 32'hAAAA5555);
        tick();
        check("stall_hold1", rdata1, 32'hAAAA5555);
        clk_en = 1'b1; raddr1 = 18'h00020;
        tick();
        check("stall_nowrite", rdata1, 32'hAAAA5555);

        // PS/2 pop: port 1 pops, port 0 does not
        raddr1 = 18'h3FF00;
        tick();
        check("ps2_rd1", rdata1, 32'h0000001C);
        check("ps2_ren_hi", {31'b0, ps2_ren}, 32'h1);
        raddr1 = 18'h00010;
        tick();
        check("ps2_ren_lo", {31'b0, ps2_ren}, 32'h0);
        raddr0 = 18'h3FF00;
        tick();
        check("ps2_rd0", rdata0, 32'h0000001C);
        check("ps2_ren_p0", {31'b0, ps2_ren}, 32'h0);
        raddr0 = 18'h00010;

        // UART transmit / receive, unmapped and write-only reads
        wr(18'h3FF01, 32'h00000041, 4'b0001);
        check("tx_data", {24'b0, uart_tx_data}, 32'h41);
        check("tx_wen_hi", {31'b0, uart_tx_wen}, 32'h1);
        raddr1 = 18'h3FF02;
        tick();
        check("tx_wen_lo", {31'b0, uart_tx_wen}, 32'h0);
        check("rx_rd", rdata1, 32'h0000005A);
        check("rx_ren_hi", {31'b0, uart_rx_ren}, 32'h1);
        raddr1 = 18'h3FF03;
        tick();
        check("rx_ren_lo", {31'b0, uart_rx_ren}, 32'h0);
        check("unmapped", rdata1, 32'h0);
        raddr1 = 18'h3FF01;
        tick();
        check("wo_read", rdata1, 32'h0);

        // Frame buffer: cell (x=2, y=1) at 0x20000 + 82
        wr(18'h20052, 32'hFFFF0F0A, 4'b0011);
        pixel_x_in = 10'd20; pixel_y_in = 10'd9; raddr1 = 18'h20052;
        tick();
        check("pixel", {20'b0, pixel}, 32'hF0A);
        check("fb_rd", rdata1, 32'h00000F0A);
        pixel_x_in = 10'd700;
        tick();
        check("pixel_off", {20'b0, pixel}, 32'h0);
        wr(18'h20052, 32'h00000300, 4'b0010);
        pixel_x_in = 10'd20;
        tick();
        check("pixel_lane", {20'b0, pixel}, 32'h30A);

        // Timer: reload 5 fires on the 5th and 10th enabled cycle
        raddr1 = 18'h3FF04;
        wr(18'h3FF04, 32'd5, 4'b1111);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("tmr_%0d", i), {31'b0, interrupts[0]},
                  (i == 4 || i == 9) ? 32'h1 : 32'h0);
        end
        check("tmr_reload_rd", rdata1, 32'd5);
        check("irq_hi_bits", {16'b0, interrupts[15:1], 1'b0}, 32'h0);
        wr(18'h3FF04, 32'd0, 4'b1111);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (interrupts[0]) hits++;
        end
        check("tmr_stopped", hits, 32'd0);

        // Reset mid-count clears timer, tx data and pending strobes
        wr(18'h3FF04, 32'd5, 4'b1111);
        tick(); tick();
        rst = 1'b1; raddr1 = 18'h3FF00;
        #2;
        check("rst_mid_irq", {16'b0, interrupts}, 32'h0);
        check("rst_mid_rd1", rdata1, 32'h0);
        check("rst_mid_tx", {24'b0, uart_tx_data}, 32'h0);
        tick();
        check("rst_mid_ps2", {31'b0, ps2_ren}, 32'h0);
        rst = 1'b0; raddr1 = 18'h3FF04;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (interrupts[0]) hits++;
        end
        check("rst_tmr_idle", hits, 32'd0);
        check("rst_reload", rdata1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
